// File: rtl/line_buffer_pkg.sv
// Shared types and width helpers for the line buffer read-side sequencer.
package line_buffer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  // Address width for a 0..n-1 range; a 1-entry range still needs one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/line_buffer_reader_if.sv
// Buffer read port plus output pixel stream of line_buffer_reader.
// LINE_BUFFER_READER_FRAME_EN adds the pix_sof/pix_eof frame markers.
interface line_buffer_reader_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 1920,
  parameter int NUM_LINES   = 3
);
  import line_buffer_pkg::*;

  logic [addr_w(NUM_LINES)-1:0]  rd_line_sel;
  logic [addr_w(LINE_WIDTH)-1:0] rd_col_sel;
  logic [PIXEL_WIDTH-1:0]        rd_data;
  logic [PIXEL_WIDTH-1:0]        pix_out;
  logic                          pix_valid;
  logic                          pix_ready;
  logic                          pix_sol;
  logic                          pix_eol;
`ifdef LINE_BUFFER_READER_FRAME_EN
  logic                          pix_sof;
  logic                          pix_eof;
`endif

  modport master (
    input  rd_data, pix_ready,
    output rd_line_sel, rd_col_sel, pix_out, pix_valid, pix_sol, pix_eol
`ifdef LINE_BUFFER_READER_FRAME_EN
    , pix_sof, pix_eof
`endif
  );

  modport slave (
    output rd_data, pix_ready,
    input  rd_line_sel, rd_col_sel, pix_out, pix_valid, pix_sol, pix_eol
`ifdef LINE_BUFFER_READER_FRAME_EN
    , pix_sof, pix_eof
`endif
  );

endinterface

// File: rtl/line_buffer_credit_cnt.sv
// Count of complete unread lines, saturating at NUM_LINES, with sticky overflow.
module line_buffer_credit_cnt #(
  parameter int NUM_LINES = 3,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_LINES);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             ovf_set_s;
  logic             dec_ok_s;

  assign dec_ok_s = dec && (count_r != ZERO_CNT);

  // Next count: a write and a read in the same cycle cancel out.
  always_comb begin
    count_nxt = count_r;
    ovf_set_s = 1'b0;
    case ({inc, dec_ok_s})
      2'b10: begin
        if (count_r == MAX_CNT) begin
          count_nxt = count_r;
          ovf_set_s = 1'b1;
        end else begin
          count_nxt = count_r + CNT_W'(1);
        end
      end
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
  end

  // Count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= ZERO_CNT;
      overflow_r <= 1'b0;
    end else begin
      count_r    <= count_nxt;
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/line_buffer_reader.sv
// Read-side sequencer: streams completed lines in raster order as valid/ready pixels.
// Optional LINE_BUFFER_READER_FRAME_EN adds FRAME_LINES, pix_sof and pix_eof.
module line_buffer_reader
  import line_buffer_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 1920,
  parameter int NUM_LINES   = 3
`ifdef LINE_BUFFER_READER_FRAME_EN
  , parameter int FRAME_LINES = 1080
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              line_done,
  line_buffer_reader_if.master              bus,
  output logic [addr_w(NUM_LINES+1)-1:0]    lines_avail,
  output logic                              overflow
);

  localparam int COL_W  = addr_w(LINE_WIDTH);
  localparam int LINE_W = addr_w(NUM_LINES);
  localparam int CNT_W  = addr_w(NUM_LINES + 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};

  rd_state_e              state_r, state_nxt;
  logic [COL_W-1:0]       col_r, col_nxt;
  logic [LINE_W-1:0]      line_r, line_nxt;
  logic [PIXEL_WIDTH-1:0] pix_r, pix_nxt;
  logic                   valid_r, valid_nxt;
  logic                   sol_r, sol_nxt;
  logic                   eol_r, eol_nxt;
  logic                   adv_s;
  logic                   consume_s;
  logic [CNT_W-1:0]       avail_s, avail_nxt_s;

`ifdef LINE_BUFFER_READER_FRAME_EN
  localparam int ROW_W = addr_w(FRAME_LINES);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_LINES - 1);
  logic [ROW_W-1:0] row_r, row_nxt;
  logic             sof_r, sof_nxt;
  logic             eof_r, eof_nxt;
`endif

  assign adv_s     = !valid_r || bus.pix_ready;
  assign consume_s = (state_r == STREAM) && adv_s && (col_r == LAST_COL);

  line_buffer_credit_cnt #(
    .NUM_LINES (NUM_LINES),
    .CNT_W     (CNT_W)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (line_done),
    .dec       (consume_s),
    .count     (avail_s),
    .count_nxt (avail_nxt_s),
    .overflow  (overflow)
  );

  // Sequencer next state; the post-update count decides whether the next line follows without a bubble.
  always_comb begin
    state_nxt = state_r;
    col_nxt   = col_r;
    line_nxt  = line_r;
    pix_nxt   = pix_r;
    valid_nxt = valid_r;
    sol_nxt   = sol_r;
    eol_nxt   = eol_r;
`ifdef LINE_BUFFER_READER_FRAME_EN
    row_nxt   = row_r;
    sof_nxt   = sof_r;
    eof_nxt   = eof_r;
`endif
    case (state_r)
      IDLE: begin
        if (valid_r && bus.pix_ready) begin
          valid_nxt = 1'b0;
        end else begin
          valid_nxt = valid_r;
        end
        if (avail_s != ZERO_CNT) begin
          state_nxt = STREAM;
        end else begin
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (adv_s) begin
          pix_nxt   = bus.rd_data;
          valid_nxt = 1'b1;
          sol_nxt   = (col_r == {COL_W{1'b0}});
          eol_nxt   = (col_r == LAST_COL);
`ifdef LINE_BUFFER_READER_FRAME_EN
          sof_nxt   = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
          eof_nxt   = (col_r == LAST_COL) && (row_r == LAST_ROW);
`endif
          if (col_r == LAST_COL) begin
            col_nxt   = {COL_W{1'b0}};
            line_nxt  = (line_r == LAST_LINE) ? {LINE_W{1'b0}} : line_r + LINE_W'(1);
`ifdef LINE_BUFFER_READER_FRAME_EN
            row_nxt   = (row_r == LAST_ROW) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
`endif
            state_nxt = (avail_nxt_s != ZERO_CNT) ? STREAM : IDLE;
          end else begin
            col_nxt   = col_r + COL_W'(1);
            state_nxt = STREAM;
          end
        end else begin
          state_nxt = STREAM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer, address and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      col_r   <= {COL_W{1'b0}};
      line_r  <= {LINE_W{1'b0}};
      pix_r   <= {PIXEL_WIDTH{1'b0}};
      valid_r <= 1'b0;
      sol_r   <= 1'b0;
      eol_r   <= 1'b0;
`ifdef LINE_BUFFER_READER_FRAME_EN
      row_r   <= {ROW_W{1'b0}};
      sof_r   <= 1'b0;
      eof_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      col_r   <= col_nxt;
      line_r  <= line_nxt;
      pix_r   <= pix_nxt;
      valid_r <= valid_nxt;
      sol_r   <= sol_nxt;
      eol_r   <= eol_nxt;
`ifdef LINE_BUFFER_READER_FRAME_EN
      row_r   <= row_nxt;
      sof_r   <= sof_nxt;
      eof_r   <= eof_nxt;
`endif
    end
  end

  assign bus.rd_line_sel = line_r;
  assign bus.rd_col_sel  = col_r;
  assign bus.pix_out     = pix_r;
  assign bus.pix_valid   = valid_r;
  assign bus.pix_sol     = sol_r;
  assign bus.pix_eol     = eol_r;
`ifdef LINE_BUFFER_READER_FRAME_EN
  assign bus.pix_sof     = sof_r;
  assign bus.pix_eof     = eof_r;
`endif
  assign lines_avail     = avail_s;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Self-checking bench for line_buffer_reader: directed scenarios plus a random
// ready/line_done phase against an in-order pixel stream model.
module tb_line_buffer_reader;
  localparam int PW = 8;
  localparam int LW = 4;
  localparam int NL = 3;
`ifdef LINE_BUFFER_READER_FRAME_EN
  localparam int FL = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_done = 1'b0;
  logic [1:0] lines_avail;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_line = 0, exp_col = 0, delivered = 0, hs_total = 0;
  int first_hs = -1, last_hs = -1, issued = 0;
  logic          stalled_prev = 1'b0;
  logic [PW-1:0] held_pix;
  logic          held_sol, held_eol;

  line_buffer_reader_if #(.PIXEL_WIDTH(PW), .LINE_WIDTH(LW), .NUM_LINES(NL)) bus();

  line_buffer_reader #(
    .PIXEL_WIDTH (PW),
    .LINE_WIDTH  (LW),
    .NUM_LINES   (NL)
`ifdef LINE_BUFFER_READER_FRAME_EN
    , .FRAME_LINES (FL)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_done   (line_done),
    .bus         (bus),
    .lines_avail (lines_avail),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Buffer model: line L, column c holds 16*L+c.
  assign bus.rd_data = PW'((16 * int'(bus.rd_line_sel)) + int'(bus.rd_col_sel));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    line_done = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; exp_line = 0; exp_col = 0; delivered = 0; hs_total = 0;
    first_hs = -1; last_hs = -1; issued = 0; stalled_prev = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_line"}, 32'(bus.rd_line_sel), 32'd0);
    chk({tag, "_col"}, 32'(bus.rd_col_sel), 32'd0);
    chk({tag, "_pix"}, 32'(bus.pix_out), 32'd0);
    chk({tag, "_valid"}, 32'(bus.pix_valid), 32'd0);
    chk({tag, "_sol"}, 32'(bus.pix_sol), 32'd0);
    chk({tag, "_eol"}, 32'(bus.pix_eol), 32'd0);
    chk({tag, "_avail"}, 32'(lines_avail), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef LINE_BUFFER_READER_FRAME_EN
    chk({tag, "_sof"}, 32'(bus.pix_sof), 32'd0);
    chk({tag, "_eof"}, 32'(bus.pix_eof), 32'd0);
`endif
  endtask

  // One clock: drive inputs, check the current cycle's outputs against the model, advance.
  task automatic step(input logic ld, input logic rdy);
    line_done = ld;
    bus.pix_ready = rdy;
    if (stalled_prev) begin
      chk("stall_valid", 32'(bus.pix_valid), 32'd1);
      chk("stall_pix", 32'(bus.pix_out), 32'(held_pix));
      chk("stall_sol", 32'(bus.pix_sol), 32'(held_sol));
      chk("stall_eol", 32'(bus.pix_eol), 32'(held_eol));
    end
    if (bus.pix_valid === 1'b1 && rdy) begin
      chk("pix", 32'(bus.pix_out), 32'(16 * exp_line + exp_col));
      chk("sol", 32'(bus.pix_sol), 32'(exp_col == 0));
      chk("eol", 32'(bus.pix_eol), 32'(exp_col == LW - 1));
`ifdef LINE_BUFFER_READER_FRAME_EN
      chk("sof", 32'(bus.pix_sof), 32'(exp_col == 0 && delivered % FL == 0));
      chk("eof", 32'(bus.pix_eof), 32'(exp_col == LW - 1 && delivered % FL == FL - 1));
`endif
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      hs_total++;
      if (exp_col == LW - 1) begin
        exp_col = 0;
        exp_line = (exp_line + 1) % NL;
        delivered++;
      end else begin
        exp_col++;
      end
    end
    stalled_prev = (bus.pix_valid === 1'b1) && !rdy;
    held_pix = bus.pix_out;
    held_sol = bus.pix_sol;
    held_eol = bus.pix_eol;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bus.pix_ready = 1'b1;
    do_reset(3);
    chk_zero("reset");

    // Single line: latency 3, four pixels, back to idle.
    step(1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b1);
    chk("s1_first", 32'(first_hs), 32'd3);
    chk("s1_last", 32'(last_hs), 32'd6);
    chk("s1_count", 32'(hs_total), 32'd4);
    chk("s1_avail", 32'(lines_avail), 32'd0);
    chk("s1_valid", 32'(bus.pix_valid), 32'd0);
    chk("s1_line", 32'(bus.rd_line_sel), 32'd1);

    // Three lines back to back: 12 contiguous pixels, line select wraps.
    do_reset(1);
    repeat (3) step(1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b1);
    chk("s2_count", 32'(hs_total), 32'd12);
    chk("s2_first", 32'(first_hs), 32'd3);
    chk("s2_span", 32'(last_hs - first_hs), 32'd11);
    chk("s2_line", 32'(bus.rd_line_sel), 32'd0);
    chk("s2_ovf", 32'(overflow), 32'd0);

    // Two lines with ready toggling 1,0,0,1.
    do_reset(1);
    for (int i = 0; i < 60; i++) step(logic'(i < 2), logic'((i % 4 == 0) || (i % 4 == 3)));
    chk("s3_count", 32'(hs_total), 32'd8);
    chk("s3_avail", 32'(lines_avail), 32'd0);

    // Saturation and overflow under a full stall, then reset mid-stall.
    do_reset(1);
    repeat (4) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("s4_avail", 32'(lines_avail), 32'd3);
    chk("s4_ovf", 32'(overflow), 32'd1);
    chk("s4_valid", 32'(bus.pix_valid), 32'd1);
    chk("s4_pix", 32'(bus.pix_out), 32'h00);
    do_reset(1);
    chk_zero("s4_rst");

    // line_done coincident with the eol capture at one line available.
    do_reset(1);
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("s5_avail", 32'(lines_avail), 32'd1);
    chk("s5_ovf", 32'(overflow), 32'd0);
    repeat (12) step(1'b0, 1'b1);
    chk("s5_count", 32'(hs_total), 32'd8);
    chk("s5_first", 32'(first_hs), 32'd3);
    chk("s5_span", 32'(last_hs - first_hs), 32'd7);

`ifdef LINE_BUFFER_READER_FRAME_EN
    // Four lines over a two-row frame; sof/eof checked per pixel by the model.
    do_reset(1);
    for (int i = 0; i < 30; i++) step(logic'((i < 3) || (i == 6)), 1'b1);
    chk("s6_count", 32'(hs_total), 32'd16);
    chk("s6_ovf", 32'(overflow), 32'd0);
`endif

    // Random ready and line_done, never more than NL lines outstanding.
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      logic ld;
      ld = logic'((issued - delivered < NL) && ($urandom_range(0, 3) == 0));
      if (ld) issued++;
      step(ld, logic'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 200 && delivered < issued; i++) step(1'b0, 1'b1);
    chk("rnd_drained", 32'(delivered), 32'(issued));
    repeat (3) step(1'b0, 1'b1);
    chk("rnd_avail", 32'(lines_avail), 32'd0);
    chk("rnd_ovf", 32'(overflow), 32'd0);
    chk("rnd_valid", 32'(bus.pix_valid), 32'd0);
    chk("rnd_line", 32'(bus.rd_line_sel), 32'(issued % NL));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_buffer_reader.md
Name: line_buffer_reader

Overview:
Read-side sequencer for the team's N-line pixel line buffer. It tracks how many complete lines the writer has filled, and drives the buffer's combinational read address (line select, column select). It streams each completed line out in raster order as a valid/ready pixel stream with start-of-line and end-of-line markers, and returns each line to the writer once it has been fully read. It sits between the line buffer and downstream consumers such as convolution, scaler or encoder stages.

Parameters:
PIXEL_WIDTH, 8, bits per pixel
LINE_WIDTH, 1920, pixels per line (>=2)
NUM_LINES, 3, lines held by the attached buffer (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
line_done  in  1  one-cycle pulse from write side: one full line written
rd_line_sel  out  $clog2(NUM_LINES)  buffer read line address
rd_col_sel  out  $clog2(LINE_WIDTH)  buffer read column address
rd_data  in  PIXEL_WIDTH  buffer read data, combinational from address
pix_out  out  PIXEL_WIDTH  output pixel
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream ready
pix_sol  out  1  pix_out is column 0
pix_eol  out  1  pix_out is column LINE_WIDTH-1
lines_avail  out  $clog2(NUM_LINES+1)  complete unread lines
overflow  out  1  sticky: line_done arrived while lines_avail==NUM_LINES

Behaviour:
- One clock, clk. Reset is synchronous, active-high (rst). All state resets: rd_line_sel=0, rd_col_sel=0, pix_out=0, pix_valid=0, pix_sol=0, pix_eol=0, lines_avail=0, overflow=0, FSM=IDLE. The line order matches a writer that also starts at line 0.
- A reset mid-line discards the partial line and any held output pixel. pix_valid is 0 on the cycle after reset.
- adv = !pix_valid || pix_ready. The output register loads only when adv=1. pix_out, pix_sol and pix_eol are held stable while pix_valid=1 and pix_ready=0.
- FSM IDLE: the output register drains (pix_valid clears on a handshake). If lines_avail!=0, go to STREAM. Addresses are held.
- FSM STREAM, when adv=1:
  - Capture pix_out<=rd_data, pix_valid<=1.
  - pix_sol<=(rd_col_sel==0), pix_eol<=(rd_col_sel==LINE_WIDTH-1).
  - rd_col_sel increments.
- FSM STREAM, when adv=0: hold all state.
- Last column captured (rd_col_sel==LINE_WIDTH-1):
  - rd_col_sel<=0; rd_line_sel increments, wrapping NUM_LINES-1 -> 0.
  - The line is consumed (decrement).
  - Next state is STREAM if the post-update lines_avail!=0, else IDLE.
- lines_avail update: +1 on line_done, -1 on consume. Both in the same cycle leaves it unchanged.
- line_done at lines_avail==NUM_LINES with no consume: the count saturates and overflow sets. overflow clears only on rst.
- Latency: line_done in cycle 0 with FSM IDLE gives first pix_valid=1 in cycle 3.
- Back-to-back lines with ready held high stream with no bubble across the line boundary: eol pixel in cycle k, next sol pixel in cycle k+1.
- Throughput is 1 pixel/clk with pix_ready=1.

Optional Feature:
LINE_BUFFER_READER_FRAME_EN:
- Defined: adds parameter FRAME_LINES (default 1080) and outputs pix_sof and pix_eof.
- A row counter increments per consumed line and wraps at FRAME_LINES-1 -> 0.
- pix_sof=pix_sol on row 0. pix_eof=pix_eol on row FRAME_LINES-1.
- Both follow the same hold rules as pix_sol and pix_eol, and both reset to 0.
- Undefined: parameter, ports and row counter are absent. All other behaviour is identical.

Decomposition:
- Package line_buffer_pkg holds:
  - the reader FSM state enum (IDLE, STREAM)
  - a localparam helper for address widths ($clog2 of LINE_WIDTH and NUM_LINES)
- One natural sub-module: line_buffer_credit_cnt. It contains the saturating lines_avail up/down counter plus the overflow flag.
- The FSM, address counters and output register live in the top.

Test Plan:
All scenarios use PIXEL_WIDTH=8, LINE_WIDTH=4, NUM_LINES=3. The buffer model holds line L, column c = 16*L+c.
1. Reset, then one line_done pulse in cycle 0, pix_ready=1 -> pix_valid in cycles 3..6 with pix_out 0x00,01,02,03; sol in cycle 3, eol in cycle 6; lines_avail back to 0; FSM IDLE.
2. Three line_done pulses back-to-back, pix_ready=1 -> 12 contiguous pixels 0x00..03, 10..13, 20..23 with no bubble; rd_line_sel wraps to 0 afterwards.
3. Two lines available, pix_ready toggling 1,0,0,1,... -> no pixel dropped or duplicated; pix_out, pix_sol and pix_eol stable while stalled; order matches scenario 2.
4. Four line_done pulses with pix_ready=0 -> lines_avail saturates at 3 and overflow=1. Assert rst for 1 cycle mid-stall -> all outputs 0 the next cycle.
5. line_done coincident with a consume (eol capture) while lines_avail=1 -> lines_avail stays 1; the next line streams with no gap.
6. With LINE_BUFFER_READER_FRAME_EN and FRAME_LINES=2: 4 lines -> pix_sof on pixel 0x00 and 0x20, pix_eof on pixel 0x13 and the following 0x03.
